// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM states, parity modes and the parity rule used by TX and RX.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Widest supported data word; narrower words are zero-extended, which leaves ^d unchanged.
  localparam int unsigned MAX_DATA_W = 9;

  // Even: bit = ^d. Odd: bit = ~^d.
  function automatic logic frame_parity(input logic [MAX_DATA_W-1:0] d, input logic mode);
    return (^d) ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the terminal count.
module uart_tx_frame_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_tick,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count; clr restarts the period so a new frame is phase-aligned.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // High when the counter will sit at terminal count in the next cycle.
  assign pre_tick_c = (cnt_d == CNT_LAST);

  // Counter and registered terminal-count flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_tick <= pre_tick_c;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, data LSB-first, optional parity, stop bit(s).
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic PARITY_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              accept;
  logic              last_stop;
  logic              serial_d, ready_d, busy_d, done_d;
  logic              bit_tick;
  logic              pre_tick_c;

  // Bit-period timing, restarted on every accepted byte.
  uart_tx_frame_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .bit_tick  (bit_tick),
    .pre_tick_c(pre_tick_c)
  );

  // Next-state logic plus next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = tx_valid && tx_ready;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (idx_q == STOP_LAST) begin
            accept  = tx_valid && tx_ready;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept from IDLE or from the last stop cycle (back-to-back frames).
    if (accept) begin
      state_d  = ST_START;
      shift_d  = tx_data;
      idx_d    = '0;
      parity_d = frame_parity(MAX_DATA_W'(tx_data), PARITY_MODE);
    end

    // Next cycle is the final cycle of the last stop bit.
    last_stop = (state_d == ST_STOP) && (idx_d == STOP_LAST) && pre_tick_c;

    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = parity_d;
      default:   serial_d = 1'b1;
    endcase

    done_d  = last_stop;
    ready_d = (state_d == ST_IDLE) || last_stop;
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      parity_q  <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      parity_q  <= parity_d;
      tx_serial <= serial_d;
      tx_ready  <= ready_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four configurations share clock and reset.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ser   [4];
  logic       rdy   [4];
  logic       bsy   [4];
  logic       dn    [4];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  // dut0: even parity, 1 stop
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(rdy[0]),
    .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  // dut1: odd parity
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(rdy[1]),
    .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  // dut2: no parity
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(rdy[2]),
    .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  // dut3: even parity, 2 stop bits
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]), .tx_ready(rdy[3]),
    .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    check($sformatf("%s_d%0d_ser", tag, d), 16'(ser[d]), 16'd1);
    check($sformatf("%s_d%0d_rdy", tag, d), 16'(rdy[d]), 16'd1);
    check($sformatf("%s_d%0d_bsy", tag, d), 16'(bsy[d]), 16'd0);
    check($sformatf("%s_d%0d_done", tag, d), 16'(dn[d]), 16'd0);
  endtask

  // Present a byte; it is accepted on the following posedge.
  task automatic start_frame(input int d, input logic [7:0] b);
    @(negedge clk);
    check($sformatf("start_d%0d_rdy", d), 16'(rdy[d]), 16'd1);
    data[d]  = b;
    valid[d] = 1'b1;
  endtask

  // Check ncyc cycles of a frame whose bit k (in transmit order) is fbits[k].
  task automatic frame_cycles(input int d, input string name, input logic [15:0] fbits,
                              input int nb, input int ncyc, input bit hold,
                              input logic [7:0] next_b, input int pulse_k);
    int last;
    last = nb * CPB;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) data[d] = next_b;
        else begin
          valid[d] = 1'b0;
          data[d]  = ~data[d];
        end
      end
      if (pulse_k != 0 && k == pulse_k) begin
        valid[d] = 1'b1;
        data[d]  = 8'hFF;
      end
      if (pulse_k != 0 && k == pulse_k + 1) valid[d] = 1'b0;
      check($sformatf("%s_ser_c%0d", name, k), 16'(ser[d]), 16'(fbits[(k-1)/CPB]));
      check($sformatf("%s_bsy_c%0d", name, k), 16'(bsy[d]), 16'd1);
      check($sformatf("%s_done_c%0d", name, k), 16'(dn[d]), 16'(k == last));
      check($sformatf("%s_rdy_c%0d", name, k), 16'(rdy[d]), 16'(k == last));
      if (dn[d] === 1'b1) done_seen++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end

    // Reset values, held and after release
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "reset_release");

    // Even parity 8'hA5: 0,1,0,1,0,0,1,0,1,0,1
    done_seen = 0;
    start_frame(0, 8'hA5);
    frame_cycles(0, "a5_even", 16'h054A, 11, 44, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk_idle(0, "a5_after");
    check("a5_done_count", 16'(done_seen), 16'd1);

    // Odd parity 8'h07: parity bit 0
    start_frame(1, 8'h07);
    frame_cycles(1, "07_odd", 16'h040E, 11, 44, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk_idle(1, "07_odd_after");

    // No parity 8'h07: 10-bit frame, 40 cycles
    start_frame(2, 8'h07);
    frame_cycles(2, "07_nopar", 16'h020E, 10, 40, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk_idle(2, "07_nopar_after");

    // Back-to-back 8'h55 then 8'hAA with tx_valid held high
    done_seen = 0;
    start_frame(0, 8'h55);
    frame_cycles(0, "b2b_55", 16'h04AA, 11, 44, 1'b1, 8'hAA, 0);
    frame_cycles(0, "b2b_aa", 16'h0554, 11, 44, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk_idle(0, "b2b_after");
    check("b2b_done_count", 16'(done_seen), 16'd2);

    // tx_valid pulse with 8'hFF during DATA of 8'h3C is ignored
    done_seen = 0;
    start_frame(0, 8'h3C);
    frame_cycles(0, "busy_3c", 16'h0478, 11, 44, 1'b0, 8'h00, 10);
    @(negedge clk);
    chk_idle(0, "busy_after");
    @(negedge clk);
    chk_idle(0, "busy_after2");
    check("busy_done_count", 16'(done_seen), 16'd1);

    // Reset during data bit 3 of 8'hF0 (line low), then 8'h81 with 2 stop bits
    done_seen = 0;
    start_frame(3, 8'hF0);
    frame_cycles(3, "rst_f0", 16'h0DE0, 12, 18, 1'b0, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle(3, "rst_async");
    repeat (3) begin
      @(negedge clk);
      chk_idle(3, "rst_held");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle(3, "rst_after_release");
    check("rst_no_done", 16'(done_seen), 16'd0);

    start_frame(3, 8'h81);
    frame_cycles(3, "81_stop2", 16'h0D02, 12, 48, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk_idle(3, "81_after");
    check("81_done_count", 16'(done_seen), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
